// File: rtl/pe_array_ctrl.sv
// Sequencer for a weight-stationary systolic array of stacked PE rows: loads weight rows,
// streams activation vectors under a global stall, drains the pipeline and flags results.
module pe_array_ctrl #(
  parameter int unsigned NUM_PE   = 32,
  parameter int unsigned NUM_ROWS = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             reuse_w,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             act_valid,
  output logic             act_ready,
  output logic             act_zero,
  output logic             W_EN,
  output logic             EN,
  output logic             out_valid,
  output logic             out_last
);

  localparam int unsigned LAT    = NUM_ROWS + NUM_PE - 1;
  localparam int unsigned WCNT_W = $clog2(NUM_ROWS + 1);
  localparam int unsigned DCNT_W = $clog2(LAT + 1);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_d;
  logic [CNT_W-1:0]  r_vcnt, w_vcnt_d;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_d;
  logic [CNT_W-1:0]  r_nv, w_nv_d;
  logic              r_loaded, w_loaded_d;
  logic [LAT-1:0]    r_tok;
  logic [CNT_W-1:0]  r_ocnt;
  logic              r_out_valid, r_out_last;
  logic              w_tok_in;
  logic              w_tok_out;
  logic              w_final_out;

  // reuse_w only steers the start decision, so it is consumed in the start cycle itself.
  always_comb begin
    w_state_d  = r_state;
    w_wcnt_d   = r_wcnt;
    w_vcnt_d   = r_vcnt;
    w_dcnt_d   = r_dcnt;
    w_nv_d     = r_nv;
    w_loaded_d = r_loaded;
    busy       = (r_state != StIdle);
    done       = 1'b0;
    w_ready    = 1'b0;
    act_ready  = 1'b0;
    act_zero   = 1'b0;
    W_EN       = 1'b0;
    EN         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_nv_d = num_vec;
          if (num_vec == '0) begin
            w_state_d = StDone;
          end else if (reuse_w && r_loaded) begin
            w_state_d = StStream;
          end else begin
            w_state_d = StLoadW;
          end
        end
      end
      StLoadW: begin
        w_ready = 1'b1;
        W_EN    = w_valid;
        if (w_valid) begin
          if (r_wcnt == WCNT_W'(NUM_ROWS - 1)) begin
            w_wcnt_d   = '0;
            w_loaded_d = 1'b1;
            w_state_d  = StStream;
          end else begin
            w_wcnt_d = r_wcnt + WCNT_W'(1);
          end
        end
      end
      StStream: begin
        act_ready = 1'b1;
        EN        = act_valid;
        if (act_valid) begin
          if (r_vcnt + CNT_W'(1) == r_nv) begin
            w_vcnt_d  = '0;
            w_state_d = StDrain;
          end else begin
            w_vcnt_d = r_vcnt + CNT_W'(1);
          end
        end
      end
      StDrain: begin
        EN       = 1'b1;
        act_zero = 1'b1;
        if (r_dcnt == DCNT_W'(LAT - 1)) begin
          w_dcnt_d  = '0;
          w_state_d = StDone;
        end else begin
          w_dcnt_d = r_dcnt + DCNT_W'(1);
        end
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Each token marks one real vector in flight; drain pushes zeros behind the last one.
  assign w_tok_in    = (r_state == StStream);
  assign w_tok_out   = r_tok[LAT-1];
  assign w_final_out = w_tok_out && (r_ocnt + CNT_W'(1) == r_nv);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= StIdle;
      r_wcnt   <= '0;
      r_vcnt   <= '0;
      r_dcnt   <= '0;
      r_nv     <= '0;
      r_loaded <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_wcnt   <= w_wcnt_d;
      r_vcnt   <= w_vcnt_d;
      r_dcnt   <= w_dcnt_d;
      r_nv     <= w_nv_d;
      r_loaded <= w_loaded_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tok       <= '0;
      r_ocnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (EN) begin
      r_tok       <= {r_tok[LAT-2:0], w_tok_in};
      r_out_valid <= w_tok_out;
      r_out_last  <= w_final_out;
      if (w_final_out) begin
        r_ocnt <= '0;
      end else if (w_tok_out) begin
        r_ocnt <= r_ocnt + CNT_W'(1);
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized self-checking bench for pe_array_ctrl; expected outputs come from a per-job
// timeline computed from the valid patterns (load end, stream end, drain, EN-edge latency).
module tb_pe_array_ctrl;

  localparam int NUM_PE   = 4;
  localparam int NUM_ROWS = 4;
  localparam int CNT_W    = 16;
  localparam int LAT      = NUM_ROWS + NUM_PE - 1;
  localparam int MAXC     = 256;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             reuse_w;
  logic             busy, done, w_ready, act_ready, act_zero, W_EN, EN, out_valid, out_last;
  logic             w_valid, act_valid;
  logic [8:0]       w_obs;

  int n_checks;
  int n_errors;
  bit model_loaded;

  pe_array_ctrl #(
    .NUM_PE  (NUM_PE),
    .NUM_ROWS(NUM_ROWS),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .num_vec  (num_vec),
    .reuse_w  (reuse_w),
    .busy     (busy),
    .done     (done),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .act_valid(act_valid),
    .act_ready(act_ready),
    .act_zero (act_zero),
    .W_EN     (W_EN),
    .EN       (EN),
    .out_valid(out_valid),
    .out_last (out_last)
  );

  always #5 CLK = ~CLK;

  assign w_obs = {busy, done, w_ready, act_ready, act_zero, W_EN, EN, out_valid, out_last};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (busy,done,w_rdy,a_rdy,a_zero,W_EN,EN,ov,ol)",
               tag, got, exp);
    end
  endtask

  // Asserts RESET mid-cycle, expects outputs to clear at once, then returns to idle.
  task automatic apply_reset(input string tag);
    #2;
    RESET = 1'b1;
    start = 1'b0;
    #1;
    check({tag, " async"}, w_obs, 0);
    @(posedge CLK);
    @(negedge CLK);
    check({tag, " held"}, w_obs, 0);
    RESET = 1'b0;
    model_loaded = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("%s idle%0d", tag, k), w_obs, 0);
    end
  endtask

  // wmode/amode: 0 always valid, 1 two-cycle gap, 2 random.
  task automatic run_job(input int id, input int nv, input bit reuse, input int wmode,
                         input int amode, input bit rand_start, input bit abort_drain);
    bit wv[MAXC], av[MAXC];
    bit e_wr[MAXC], e_ar[MAXC], e_az[MAXC], e_wen[MAXC], e_en[MAXC], e_ov[MAXC], e_ol[MAXC];
    int s0, done_c, hits, en_idx, c, abort_c;
    logic [8:0] exp_v;
    for (int i = 0; i < MAXC; i++) begin
      wv[i] = (wmode == 2 && i < MAXC / 2) ? ($urandom_range(3) != 0) : 1'b1;
      av[i] = (amode == 2 && i < MAXC / 2) ? ($urandom_range(3) != 0) : 1'b1;
      e_wr[i] = 0; e_ar[i] = 0; e_az[i] = 0; e_wen[i] = 0;
      e_en[i] = 0; e_ov[i] = 0; e_ol[i] = 0;
    end
    if (wmode == 1) begin
      wv[3] = 1'b0;
      wv[4] = 1'b0;
    end
    c = 1;
    if (nv != 0 && !(reuse && model_loaded)) begin
      hits = 0;
      while (hits < NUM_ROWS) begin
        e_wr[c]  = 1'b1;
        e_wen[c] = wv[c];
        if (wv[c]) hits++;
        c++;
      end
      model_loaded = 1'b1;
    end
    s0 = c;
    if (amode == 1) begin
      av[s0 + 1] = 1'b0;
      av[s0 + 2] = 1'b0;
    end
    if (nv == 0) begin
      done_c = 1;
    end else begin
      hits = 0;
      while (hits < nv) begin
        e_ar[c] = 1'b1;
        e_en[c] = av[c];
        if (av[c]) hits++;
        c++;
      end
      for (int d = 0; d < LAT; d++) begin
        e_en[c] = 1'b1;
        e_az[c] = 1'b1;
        c++;
      end
      done_c = c;
    end
    // A vector accepted on EN edge k appears on the bus after EN edge k+LAT.
    en_idx = 0;
    for (int i = 1; i <= done_c + 1; i++) begin
      if (e_en[i-1]) begin
        en_idx++;
        if (en_idx > LAT && en_idx <= LAT + nv) e_ov[i] = 1'b1;
        if (en_idx == LAT + nv) e_ol[i] = 1'b1;
      end
    end
    abort_c = abort_drain ? done_c - 3 : -1;

    @(posedge CLK);
    #1;
    start     = 1'b1;
    num_vec   = CNT_W'(nv);
    reuse_w   = reuse;
    w_valid   = 1'b0;
    act_valid = 1'b0;
    @(negedge CLK);
    check($sformatf("job%0d c0", id), w_obs, 0);
    for (int i = 1; i <= done_c + 1; i++) begin
      @(posedge CLK);
      #1;
      start     = (rand_start && i <= done_c) ? 1'($urandom_range(1)) : 1'b0;
      num_vec   = CNT_W'($urandom);
      reuse_w   = 1'($urandom_range(1));
      w_valid   = wv[i];
      act_valid = av[i];
      @(negedge CLK);
      exp_v = {i <= done_c, i == done_c, e_wr[i], e_ar[i], e_az[i], e_wen[i], e_en[i],
               e_ov[i], e_ol[i]};
      check($sformatf("job%0d c%0d", id, i), w_obs, 32'(exp_v));
      if (i == abort_c) begin
        apply_reset($sformatf("job%0d drain-reset", id));
        return;
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    model_loaded = 1'b0;
    RESET        = 1'b1;
    start        = 1'b0;
    num_vec      = '0;
    reuse_w      = 1'b0;
    w_valid      = 1'b0;
    act_valid    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset", w_obs, 0);
    RESET = 1'b0;
    @(negedge CLK);
    check("idle after reset", w_obs, 0);

    run_job(1, 3, 1'b0, 0, 0, 1'b0, 1'b0);  // full load, no stalls
    run_job(2, 3, 1'b1, 0, 1, 1'b0, 1'b0);  // reuse, act stall after vector 1
    apply_reset("mid-idle");
    run_job(3, 3, 1'b1, 1, 0, 1'b0, 1'b0);  // reuse after reset still loads, w stall
    run_job(4, 0, 1'b0, 0, 0, 1'b0, 1'b0);  // empty job
    run_job(5, 4, 1'b1, 0, 0, 1'b1, 1'b0);  // start pulses while busy
    run_job(6, 3, 1'b1, 0, 0, 1'b0, 1'b1);  // reset during drain
    run_job(7, 2, 1'b1, 0, 0, 1'b0, 1'b0);  // weights lost, reload
    for (int j = 0; j < 16; j++) begin
      run_job(10 + j, $urandom_range(6), 1'($urandom_range(1)), 2, 2, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
